timer_irq_service_master: RTL and testbench



---
 rtl/timer_irq_service_master.sv | 109 ++++++++++
 tb/tb_timer_irq_service_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_service_master.sv
// Avalon-MM master that programs the interval timer after reset and services its timeout IRQ
// in hardware: status read, status clear, tick count advance.
module timer_irq_service_master #(
  parameter logic [31:0] PERIOD_DEFAULT = 32'd9_999_999,
  parameter logic [15:0] CTRL_WORD      = 16'h0007,
  parameter int unsigned COUNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               cfg_load,
  input  logic [31:0]        cfg_period,
  input  logic               timer_irq,
  input  logic [15:0]        timer_readdata,
  output logic [2:0]         timer_address,
  output logic               timer_chipselect,
  output logic               timer_write_n,
  output logic [15:0]        timer_writedata,
  output logic [COUNT_W-1:0] tick_count,
  output logic               tick_pulse,
  output logic               busy,
  output logic               stalled
);

  typedef enum logic [2:0] {
    StInitPl, StInitPh, StInitCtl, StIdle, StRdStat, StRdWait, StClr, StGuard
  } state_e;

  state_e      state;
  logic [31:0] period;
  logic        pend_cfg;

  assign busy = (state != StIdle);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= StInitPl;
      period           <= PERIOD_DEFAULT;
      pend_cfg         <= 1'b0;
      timer_address    <= 3'd0;
      timer_chipselect <= 1'b0;
      timer_write_n    <= 1'b1;
      timer_writedata  <= 16'd0;
      tick_count       <= '0;
      tick_pulse       <= 1'b0;
      stalled          <= 1'b0;
    end else begin
      // Every access is a single cycle; strobes fall back to idle unless a state re-asserts them.
      timer_chipselect <= 1'b0;
      timer_write_n    <= 1'b1;
      tick_pulse       <= 1'b0;
      if (cfg_load) begin
        period   <= cfg_period;
        pend_cfg <= 1'b1;
      end
      unique case (state)
        StInitPl: begin
          timer_chipselect <= 1'b1;
          timer_write_n    <= 1'b0;
          timer_address    <= 3'd2;
          timer_writedata  <= period[15:0];
          state            <= StInitPh;
        end
        StInitPh: begin
          timer_chipselect <= 1'b1;
          timer_write_n    <= 1'b0;
          timer_address    <= 3'd3;
          timer_writedata  <= period[31:16];
          state            <= StInitCtl;
        end
        StInitCtl: begin
          timer_chipselect <= 1'b1;
          timer_write_n    <= 1'b0;
          timer_address    <= 3'd1;
          timer_writedata  <= CTRL_WORD;
          stalled          <= 1'b0;
          state            <= StIdle;
        end
        StIdle: begin
          // The status read is launched here so the clear lands three cycles after the IRQ.
          if (enable && timer_irq) begin
            timer_chipselect <= 1'b1;
            timer_address    <= 3'd0;
            timer_writedata  <= 16'd0;
            state            <= StRdStat;
          end else if (cfg_load || pend_cfg) begin
            pend_cfg <= 1'b0;
            state    <= StInitPl;
          end
        end
        StRdStat: state <= StRdWait;
        StRdWait: begin
          if (!timer_readdata[1]) stalled <= 1'b1;
          timer_chipselect <= 1'b1;
          timer_write_n    <= 1'b0;
          timer_address    <= 3'd0;
          timer_writedata  <= 16'd0;
          tick_count       <= tick_count + COUNT_W'(1);
          tick_pulse       <= 1'b1;
          state            <= StClr;
        end
        StClr:   state <= StGuard;
        StGuard: state <= StIdle;
        default: state <= StInitPl;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_service_master.sv
// Scoreboard bench: stimulus pushes expected bus accesses and tick counts, monitors pop and compare.
module tb_timer_irq_service_master;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic          cfg_load = 1'b0;
  logic [31:0]   cfg_period = 32'd0;
  logic          timer_irq = 1'b0;
  logic [15:0]   timer_readdata = 16'd0;
  logic [2:0]    timer_address;
  logic          timer_chipselect;
  logic          timer_write_n;
  logic [15:0]   timer_writedata;
  logic [CW-1:0] tick_count;
  logic          tick_pulse;
  logic          busy;
  logic          stalled;

  timer_irq_service_master #(.COUNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_load(cfg_load),
    .cfg_period(cfg_period), .timer_irq(timer_irq), .timer_readdata(timer_readdata),
    .timer_address(timer_address), .timer_chipselect(timer_chipselect),
    .timer_write_n(timer_write_n), .timer_writedata(timer_writedata),
    .tick_count(tick_count), .tick_pulse(tick_pulse), .busy(busy), .stalled(stalled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer model: irq set on request, cleared by a status write; registered status readback.
  logic irq_req = 1'b0;
  logic run_bit = 1'b1;
  always @(posedge clk) begin
    if (timer_chipselect && !timer_write_n && timer_address == 3'd0) timer_irq <= 1'b0;
    else if (irq_req) timer_irq <= 1'b1;
    timer_readdata <= (timer_chipselect && timer_write_n && timer_address == 3'd0) ?
                      {14'd0, run_bit, timer_irq} : 16'd0;
  end

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [15:0] data;
    int          at;
  } acc_t;

  acc_t          bus_q[$];
  logic [CW-1:0] tick_q[$];
  logic [CW-1:0] exp_count = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    acc_t e;
    if (timer_chipselect) begin
      if (bus_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_access: got addr %0d write_n %b data %h, expected none (cycle %0d)",
                 timer_address, timer_write_n, timer_writedata, cyc);
      end else begin
        e = bus_q.pop_front();
        check("bus_addr", 32'(timer_address), 32'(e.addr));
        check("bus_write_n", 32'(timer_write_n), 32'(!e.wr));
        if (e.wr) check("bus_wdata", 32'(timer_writedata), 32'(e.data));
        if (e.at != 0) check("bus_cycle", cyc, e.at);
      end
    end
    if (tick_pulse) begin
      if (tick_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_tick: got count %0d, expected no pulse", tick_count);
      end else begin
        check("tick_count", 32'(tick_count), 32'(tick_q.pop_front()));
      end
    end
  end

  task automatic push_acc(input logic [2:0] a, input logic w, input logic [15:0] d, input int at);
    acc_t e;
    e.addr = a;
    e.wr   = w;
    e.data = d;
    e.at   = at;
    bus_q.push_back(e);
  endtask

  task automatic push_init(input logic [31:0] p, input int at);
    push_acc(3'd2, 1'b1, p[15:0], at);
    push_acc(3'd3, 1'b1, p[31:16], (at == 0) ? 0 : at + 1);
    push_acc(3'd1, 1'b1, 16'h0007, (at == 0) ? 0 : at + 2);
  endtask

  // k: first cycle the IDLE FSM sees irq (0 = timing unchecked).
  task automatic expect_service(input int k);
    push_acc(3'd0, 1'b0, 16'd0, (k == 0) ? 0 : k + 1);
    push_acc(3'd0, 1'b1, 16'd0, (k == 0) ? 0 : k + 3);
    exp_count = exp_count + 1'b1;
    tick_q.push_back(exp_count);
  endtask

  task automatic raise_irq(output int k);
    irq_req = 1'b1;
    @(negedge clk);
    irq_req = 1'b0;
    k = cyc;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (!busy && bus_q.size() == 0 && tick_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: got busy %b with %0d accesses and %0d ticks pending, expected idle",
               busy, bus_q.size(), tick_q.size());
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_cs", 32'(timer_chipselect), 32'd0);
    check("rst_write_n", 32'(timer_write_n), 32'd1);
    check("rst_addr", 32'(timer_address), 32'd0);
    check("rst_wdata", 32'(timer_writedata), 32'd0);
    check("rst_count", 32'(tick_count), 32'd0);
    check("rst_pulse", 32'(tick_pulse), 32'd0);
    check("rst_stalled", 32'(stalled), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    int k;
    int r;
    repeat (3) @(negedge clk);
    check_reset_outputs();

    // Init sequence straight after reset release.
    r = cyc;
    push_init(32'h0098_967F, r + 1);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_after_init", 32'(busy), 32'd0);
    wait_idle();

    // Plain services with exact IRQ-to-clear latency.
    for (int i = 0; i < 5; i++) begin
      raise_irq(k);
      expect_service(k);
      wait_idle();
    end
    check("no_double_count", 32'(tick_count), 32'd5);

    // RUN=0 during a service sets stalled, which stays set through a clean service.
    run_bit = 1'b0;
    raise_irq(k);
    expect_service(k);
    wait_idle();
    run_bit = 1'b1;
    check("stalled_set", 32'(stalled), 32'd1);
    raise_irq(k);
    expect_service(k);
    wait_idle();
    check("stalled_sticky", 32'(stalled), 32'd1);

    // cfg_load mid-service: service completes, then reprogram; INIT_CTL clears stalled.
    raise_irq(k);
    expect_service(k);
    push_init(32'h0001_0002, 0);
    @(negedge clk);
    cfg_load = 1'b1;
    cfg_period = 32'h0001_0002;
    @(negedge clk);
    cfg_load = 1'b0;
    wait_idle();
    check("stalled_cleared", 32'(stalled), 32'd0);

    // cfg_load and irq seen together in IDLE: irq first.
    raise_irq(k);
    expect_service(k);
    push_init(32'hABCD_1234, 0);
    cfg_load = 1'b1;
    cfg_period = 32'hABCD_1234;
    @(negedge clk);
    cfg_load = 1'b0;
    wait_idle();

    // enable low holds off service; raising it starts the read next cycle.
    enable = 1'b0;
    raise_irq(k);
    repeat (6) @(negedge clk);
    check("disabled_busy", 32'(busy), 32'd0);
    check("disabled_irq_held", 32'(timer_irq), 32'd1);
    enable = 1'b1;
    expect_service(cyc);
    wait_idle();

    // Wrap the 4-bit counter (counts 11..15, 0, 1).
    for (int i = 0; i < 7; i++) begin
      raise_irq(k);
      expect_service(k);
      wait_idle();
    end
    check("count_after_wrap", 32'(tick_count), 32'd1);

    // Reset during RD_WAIT abandons the clear; init re-runs, then the still-high irq is serviced.
    raise_irq(k);
    push_acc(3'd0, 1'b0, 16'd0, k + 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    exp_count = '0;
    @(negedge clk);
    r = cyc;
    push_init(32'h0098_967F, r + 1);
    expect_service(0);
    reset_n = 1'b1;
    wait_idle();
    check("count_after_reset_service", 32'(tick_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
